// File: rtl/divider_taint_track_bitwise.sv
// Restoring unsigned divider with bit-level taint tracking.
// Runs in constant time: one LOAD cycle, WIDTH iteration cycles, one DONE cycle.
// Taint travels with the data bits. A step whose compare depends on tainted
// bits taints its quotient bit and the whole partial remainder.
//
// Handshake: start is sampled only in IDLE. busy is high from the cycle after
// that sample until the result is ready. done is a single-cycle pulse, and
// quotient/remainder stay stable from that pulse until the next division
// completes. start/start_t are ignored while busy or done is high.
module divider_taint_track_bitwise #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] dividend_t,
  input  logic [WIDTH-1:0] divisor,
  input  logic [WIDTH-1:0] divisor_t,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] quotient_t,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] remainder_t,
  output logic             busy,
  output logic             busy_t,
  output logic             done,
  output logic             done_t,
  output logic [1:0]       o_dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_rem_t;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_quo_t;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] r_dsr_t;
  logic             r_ctrl_t;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q_out;
  logic [WIDTH-1:0] r_q_out_t;
  logic [WIDTH-1:0] r_r_out;
  logic [WIDTH-1:0] r_r_out_t;

  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_rem_sh_t;
  logic [WIDTH-1:0] w_diff;
  logic             w_sub;
  logic             w_ct;
  logic             w_acc;
  logic [WIDTH-1:0] w_carry_t;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_rem_t_nx;
  logic [WIDTH-1:0] w_quo_nx;
  logic [WIDTH-1:0] w_quo_t_nx;

  // One restoring step. The compare is WIDTH+1 bits wide so the shifted
  // remainder never overflows. Only the low WIDTH bits of the difference are
  // kept, because a successful subtract always leaves a value below the divisor.
  always_comb begin
    w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
    w_rem_sh_t = {r_rem_t, r_quo_t[WIDTH-1]};
    w_sub      = (w_rem_sh >= {1'b0, r_dsr});
    w_diff     = w_rem_sh[WIDTH-1:0] - r_dsr;
    w_ct       = (|w_rem_sh_t) | (|r_dsr_t);
    w_acc      = 1'b0;
    w_carry_t  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_acc        = w_acc | w_rem_sh_t[i] | r_dsr_t[i];
      w_carry_t[i] = w_acc;
    end
    w_rem_nx   = w_sub ? w_diff : w_rem_sh[WIDTH-1:0];
    if (w_ct) begin
      w_rem_t_nx = '1;
    end else if (w_sub) begin
      w_rem_t_nx = w_carry_t;
    end else begin
      w_rem_t_nx = w_rem_sh_t[WIDTH-1:0];
    end
    w_quo_nx   = {r_quo[WIDTH-2:0], w_sub};
    w_quo_t_nx = {r_quo_t[WIDTH-2:0], w_ct};
  end

  // Control FSM, datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_rem     <= '0;
      r_rem_t   <= '0;
      r_quo     <= '0;
      r_quo_t   <= '0;
      r_dsr     <= '0;
      r_dsr_t   <= '0;
      r_ctrl_t  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_q_out   <= '0;
      r_q_out_t <= '0;
      r_r_out   <= '0;
      r_r_out_t <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_LOAD;
            r_ctrl_t <= start_t;
            r_busy   <= 1'b1;
          end
        end
        S_LOAD: begin
          r_quo   <= dividend;
          r_quo_t <= dividend_t;
          r_dsr   <= divisor;
          r_dsr_t <= divisor_t;
          r_rem   <= '0;
          r_rem_t <= '0;
          r_cnt   <= CW'(WIDTH);
          r_state <= S_ITER;
        end
        S_ITER: begin
          r_rem   <= w_rem_nx;
          r_rem_t <= w_rem_t_nx;
          r_quo   <= w_quo_nx;
          r_quo_t <= w_quo_t_nx;
          r_cnt   <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state   <= S_DONE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_q_out   <= w_quo_nx;
            r_q_out_t <= w_quo_t_nx;
            r_r_out   <= w_rem_nx;
            r_r_out_t <= w_rem_t_nx;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign quotient    = r_q_out;
  assign remainder   = r_r_out;
  assign quotient_t  = r_q_out_t | {WIDTH{r_ctrl_t}};
  assign remainder_t = r_r_out_t | {WIDTH{r_ctrl_t}};
  assign busy        = r_busy;
  assign busy_t      = r_busy & r_ctrl_t;
  assign done        = r_done;
  assign done_t      = r_done & r_ctrl_t;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_divider_taint_track_bitwise.sv
// Bench for divider_taint_track_bitwise at WIDTH=8: directed vectors,
// randomized operands and taints, ignored start, and reset abort.
module tb_divider_taint_track_bitwise;

  localparam int W    = 8;
  localparam int NCYC = W + 6;

  logic         clk;
  logic         rst;
  logic         start, start_t;
  logic [W-1:0] dividend, dividend_t, divisor, divisor_t;
  logic [W-1:0] quotient, quotient_t, remainder, remainder_t;
  logic         busy, busy_t, done, done_t;
  logic [1:0]   dbg_state;

  int nvec = 0;
  int nerr = 0;
  logic [W-1:0] exp_q[$];

  divider_taint_track_bitwise #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .start(start), .start_t(start_t),
    .dividend(dividend), .dividend_t(dividend_t),
    .divisor(divisor), .divisor_t(divisor_t),
    .quotient(quotient), .quotient_t(quotient_t),
    .remainder(remainder), .remainder_t(remainder_t),
    .busy(busy), .busy_t(busy_t),
    .done(done), .done_t(done_t),
    .o_dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer division; taint derived from which operands carry taint.
  function automatic void ref_model(input logic [W-1:0] a, b, at, bt, input logic st,
                                    output logic [W-1:0] q, r, qt, rt);
    logic seen;
    if (b == 0) begin q = '1; r = a; end
    else begin q = a / b; r = a % b; end
    seen = 1'b0;
    qt = '0;
    for (int i = W - 1; i >= 0; i--) begin
      seen = seen | at[i];
      qt[i] = seen;
    end
    if (bt != 0) qt = '1;
    rt = (at != 0 || bt != 0) ? '1 : '0;
    if (st) begin qt = '1; rt = '1; end
  endfunction

  // Driver: issues one division and records per-cycle traces (cycle 0 = start cycle).
  task automatic run_op(input logic [W-1:0] a, b, at, bt, input logic st, input int inj_cyc,
                        output logic [31:0] busy_tr, busy_t_tr, done_tr, done_t_tr,
                        output logic [W-1:0] q, r, qt, rt, qh, rh);
    busy_tr = '0; busy_t_tr = '0; done_tr = '0; done_t_tr = '0;
    q = '0; r = '0; qt = '0; rt = '0;
    @(negedge clk);
    dividend = a; divisor = b; dividend_t = at; divisor_t = bt;
    start = 1'b1; start_t = st;
    @(posedge clk);
    #1;
    start = 1'b0; start_t = 1'b0;
    for (int c = 1; c <= NCYC; c++) begin
      @(negedge clk);
      busy_tr[c] = busy; busy_t_tr[c] = busy_t;
      done_tr[c] = done; done_t_tr[c] = done_t;
      if (done === 1'b1) begin
        q = quotient; r = remainder; qt = quotient_t; rt = remainder_t;
      end
      if (c == 2) begin
        dividend = W'($urandom); divisor = W'($urandom);
        dividend_t = W'($urandom); divisor_t = W'($urandom);
      end
      start = (c == inj_cyc); start_t = (c == inj_cyc);
    end
    start = 1'b0; start_t = 1'b0;
    qh = quotient; rh = remainder;
  endtask

  function automatic logic [31:0] exp_busy_tr();
    return 32'((64'd1 << (W + 2)) - 64'd2);
  endfunction

  function automatic logic [31:0] exp_done_tr();
    return 32'(64'd1 << (W + 2));
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0; start_t = 1'b0;
    dividend = '0; divisor = '0; dividend_t = '0; divisor_t = '0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({quotient, remainder, quotient_t, remainder_t, busy, busy_t, done, done_t} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got q=%h r=%h qt=%h rt=%h b=%b bt=%b d=%b dt=%b want all 0",
               quotient, remainder, quotient_t, remainder_t, busy, busy_t, done, done_t);
    end
    start = 1'b1; start_t = 1'b1;
    repeat (2) @(negedge clk);
    nvec++;
    if ({busy, busy_t, done} !== 3'b000) begin
      nerr++;
      $display("FAIL reset_blocks_start: got busy=%b busy_t=%b done=%b want 000", busy, busy_t, done);
    end
    start = 1'b0; start_t = 1'b0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[4] = '{8'd100, 8'hFF, 8'd50, 8'd9};
    logic [W-1:0] tb[4] = '{8'd7, 8'd0, 8'd5, 8'd3};
    logic [W-1:0] tbt[4] = '{8'h00, 8'h00, 8'h01, 8'h00};
    logic         tst[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] b_tr, bt_tr, d_tr, dt_tr;
    logic [W-1:0] q, r, qt, rt, qh, rh, eq, er, eqt, ert;
    for (int k = 0; k < 4; k++) begin
      run_op(ta[k], tb[k], '0, tbt[k], tst[k], 0, b_tr, bt_tr, d_tr, dt_tr, q, r, qt, rt, qh, rh);
      ref_model(ta[k], tb[k], '0, tbt[k], tst[k], eq, er, eqt, ert);
      nvec++;
      if (d_tr !== exp_done_tr()) begin
        nerr++; $display("FAIL dir%0d_done_timing: got %h want %h", k, d_tr, exp_done_tr());
      end
      nvec++;
      if (b_tr !== exp_busy_tr()) begin
        nerr++; $display("FAIL dir%0d_busy_timing: got %h want %h", k, b_tr, exp_busy_tr());
      end
      nvec++;
      if ({q, r} !== {eq, er}) begin
        nerr++; $display("FAIL dir%0d_result: got q=%0d r=%0d want q=%0d r=%0d", k, q, r, eq, er);
      end
      nvec++;
      if ({qt, rt} !== {eqt, ert}) begin
        nerr++; $display("FAIL dir%0d_taint: got qt=%h rt=%h want qt=%h rt=%h", k, qt, rt, eqt, ert);
      end
      nvec++;
      if (bt_tr !== (tst[k] ? exp_busy_tr() : 32'h0) || dt_tr !== (tst[k] ? exp_done_tr() : 32'h0)) begin
        nerr++; $display("FAIL dir%0d_ctrl_taint: got bt=%h dt=%h want st=%b", k, bt_tr, dt_tr, tst[k]);
      end
      nvec++;
      if ({qh, rh} !== {eq, er}) begin
        nerr++; $display("FAIL dir%0d_hold: got q=%0d r=%0d want q=%0d r=%0d", k, qh, rh, eq, er);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] b_tr, bt_tr, d_tr, dt_tr;
    logic [W-1:0] a, b, at, bt, q, r, qt, rt, qh, rh, eq, er, eqt, ert, pq, pr;
    logic st;
    for (int k = 0; k < 30; k++) begin
      a  = W'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      at = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
      bt = ($urandom_range(0, 4) == 0) ? W'($urandom) : '0;
      st = ($urandom_range(0, 5) == 0);
      ref_model(a, b, at, bt, st, eq, er, eqt, ert);
      exp_q.push_back(eq);
      exp_q.push_back(er);
      run_op(a, b, at, bt, st, 0, b_tr, bt_tr, d_tr, dt_tr, q, r, qt, rt, qh, rh);
      pq = exp_q.pop_front();
      pr = exp_q.pop_front();
      nvec++;
      if ({q, r} !== {pq, pr}) begin
        nerr++; $display("FAIL rnd%0d_result: %0d/%0d got q=%0d r=%0d want q=%0d r=%0d", k, a, b, q, r, pq, pr);
      end
      nvec++;
      if ({qt, rt} !== {eqt, ert}) begin
        nerr++; $display("FAIL rnd%0d_taint: at=%h bt=%h st=%b got qt=%h rt=%h want qt=%h rt=%h",
                         k, at, bt, st, qt, rt, eqt, ert);
      end
      nvec++;
      if (d_tr !== exp_done_tr() || b_tr !== exp_busy_tr()) begin
        nerr++; $display("FAIL rnd%0d_timing: got busy=%h done=%h want busy=%h done=%h",
                         k, b_tr, d_tr, exp_busy_tr(), exp_done_tr());
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] b_tr, bt_tr, d_tr, dt_tr;
    logic [W-1:0] q, r, qt, rt, qh, rh;
    run_op(8'd200, 8'd9, '0, '0, 1'b0, 4, b_tr, bt_tr, d_tr, dt_tr, q, r, qt, rt, qh, rh);
    nvec++;
    if (d_tr !== exp_done_tr()) begin
      nerr++; $display("FAIL ignore_done_timing: got %h want %h", d_tr, exp_done_tr());
    end
    nvec++;
    if ({q, r, qt, rt} !== {8'd22, 8'd2, 8'h00, 8'h00}) begin
      nerr++; $display("FAIL ignore_result: got q=%0d r=%0d qt=%h rt=%h want q=22 r=2 qt=00 rt=00", q, r, qt, rt);
    end
    nvec++;
    if (bt_tr !== 32'h0) begin
      nerr++; $display("FAIL ignore_busy_t: got %h want 0", bt_tr);
    end
  endtask

  task automatic test_abort_reset();
    logic [31:0] b_tr, bt_tr, d_tr, dt_tr;
    logic [W-1:0] q, r, qt, rt, qh, rh;
    logic done_seen;
    done_seen = 1'b0;
    @(negedge clk);
    dividend = 8'd123; divisor = 8'd4; dividend_t = 8'h10; divisor_t = '0;
    start = 1'b1; start_t = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; start_t = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      done_seen = done_seen | done;
      start = (c == 4); start_t = (c == 4);
    end
    start = 1'b0; start_t = 1'b0;
    rst = 1'b0;
    #1;
    nvec++;
    if ({quotient, remainder, quotient_t, remainder_t, busy, busy_t, done, done_t} !== '0) begin
      nerr++;
      $display("FAIL abort_outputs: got q=%h r=%h qt=%h rt=%h b=%b bt=%b d=%b dt=%b want all 0",
               quotient, remainder, quotient_t, remainder_t, busy, busy_t, done, done_t);
    end
    repeat (3) begin
      @(negedge clk);
      done_seen = done_seen | done;
    end
    rst = 1'b1;
    for (int c = 0; c < W + 4; c++) begin
      @(negedge clk);
      done_seen = done_seen | done | busy;
    end
    nvec++;
    if (done_seen !== 1'b0) begin
      nerr++; $display("FAIL abort_no_done: got activity=%b want 0", done_seen);
    end
    run_op(8'd77, 8'd5, '0, '0, 1'b0, 0, b_tr, bt_tr, d_tr, dt_tr, q, r, qt, rt, qh, rh);
    nvec++;
    if (d_tr !== exp_done_tr()) begin
      nerr++; $display("FAIL abort_restart_timing: got %h want %h", d_tr, exp_done_tr());
    end
    nvec++;
    if ({q, r, qt, rt} !== {8'd15, 8'd2, 8'h00, 8'h00}) begin
      nerr++; $display("FAIL abort_restart_result: got q=%0d r=%0d qt=%h rt=%h want q=15 r=2 qt=00 rt=00", q, r, qt, rt);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_abort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
